// File: rtl/j_arith_pkg.sv
// Shared arithmetic package: sequencer states, default datapath width and
// the counter-width helper used by the bit-serial arithmetic blocks.
package j_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int J_DEFAULT_WIDTH     = 4;
    localparam int J_DEFAULT_CNT_WIDTH = $clog2(J_DEFAULT_WIDTH);

    // Width of a counter that indexes bits 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/j_serial_subtractor_fullsub.sv
// One-bit full-subtractor cell: D = a - b - borrowin, with borrow out.
// Port order mirrors the team's full-adder cell so the two are interchangeable.
module jfullsubtractor (
    output logic D,
    output logic borrowout,
    input  logic a,
    input  logic b,
    input  logic borrowin
);

    always_comb begin
        D         = a ^ b ^ borrowin;
        borrowout = (~a & b) | (~(a ^ b) & borrowin);
    end

endmodule

// File: rtl/j_serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: Y = A - B - borrowin, one bit per cycle
// through a single full-subtractor cell, with a start/busy/done handshake.
module j_serial_subtractor
    import j_arith_pkg::*;
#(
    parameter int WIDTH = J_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrowin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             borrowout,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] y_sr;
    logic             bor;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             bor_next;

    jfullsubtractor u_cell (
        .D        (d),
        .borrowout(bor_next),
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .borrowin (bor)
    );

    // Result bits enter y_sr at the MSB end; the visible outputs only load on
    // the final bit so partial differences never reach the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            y_sr      <= '0;
            bor       <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Y         <= '0;
            borrowout <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        bor   <= borrowin;
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    bor  <= bor_next;
                    y_sr <= {d, y_sr[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        Y         <= {d, y_sr[WIDTH-1:1]};
                        borrowout <= bor_next;
                        // d is the result MSB on the last step
                        ovf       <= (a_msb ^ b_msb) & (d ^ a_msb);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_j_serial_subtractor.sv
// Self-checking bench for j_serial_subtractor at WIDTH=4 and WIDTH=8, using a
// scoreboard of expected differences filled at start and drained at done.
module tb_j_serial_subtractor;

    typedef struct packed {
        logic [7:0] y;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, y4;
    logic       rst8, start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, y8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    j_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4), .borrowin(bin4),
        .busy(busy4), .done(done4), .Y(y4), .borrowout(bout4), .ovf(ovf4)
    );

    j_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8), .borrowin(bin8),
        .busy(busy8), .done(done8), .Y(y8), .borrowout(bout8), .ovf(ovf8)
    );

    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic bin);
        logic [8:0] mask;
        logic [8:0] full;
        exp_t       e;
        mask   = (9'd1 << w) - 9'd1;
        full   = ({1'b0, a} & mask) - ({1'b0, b} & mask) - {8'd0, bin};
        e.y    = full[7:0] & mask[7:0];
        e.bout = full[w];
        e.ovf  = (a[w-1] ^ b[w-1]) & (e.y[w-1] ^ a[w-1]);
        return e;
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction

    function automatic logic cur_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [7:0] a,
                         input logic [7:0] b, input logic bin);
        if (w == 4) begin
            start4 = st; a4 = a[3:0]; b4 = b[3:0]; bin4 = bin;
        end else begin
            start8 = st; a8 = a; b8 = b; bin8 = bin;
        end
    endtask

    // Waits for idle, presents one start pulse and leaves us at the negedge after the accept edge.
    task automatic apply_stimulus(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic bin, input bit track);
        int n = 0;
        while (cur_busy(w) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_before_start_w%0d", w), {31'd0, cur_busy(w)}, 32'd0);
        drive(w, 1'b1, a, b, bin);
        if (track) sb.push_back(model(w, a, b, bin));
        @(negedge clk);
        drive(w, 1'b0, 8'd0, 8'd0, 1'b0);
        check($sformatf("busy_after_accept_w%0d", w), {31'd0, cur_busy(w)}, 32'd1);
    endtask

    task automatic check_output(input int w, input int elapsed);
        int   cycles = elapsed;
        exp_t e;
        do begin
            @(negedge clk);
            cycles++;
        end while (!cur_done(w) && cycles < 40);
        check($sformatf("latency_w%0d", w), cycles, w);
        if (cur_done(w)) begin
            check("scoreboard_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (w == 4) begin
                    check("y_w4", {28'd0, y4}, {24'd0, e.y});
                    check("borrowout_w4", {31'd0, bout4}, {31'd0, e.bout});
                    check("ovf_w4", {31'd0, ovf4}, {31'd0, e.ovf});
                end else begin
                    check("y_w8", {24'd0, y8}, {24'd0, e.y});
                    check("borrowout_w8", {31'd0, bout8}, {31'd0, e.bout});
                    check("ovf_w8", {31'd0, ovf8}, {31'd0, e.ovf});
                end
            end
            @(negedge clk);
            check($sformatf("done_single_cycle_w%0d", w), {31'd0, cur_done(w)}, 32'd0);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rbin;
        bit         saw_done;

        rst4 = 1'b1; rst8 = 1'b1;
        drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
        drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy4}, 32'd0);
        check("reset_done", {31'd0, done4}, 32'd0);
        check("reset_y", {28'd0, y4}, 32'd0);
        check("reset_borrowout", {31'd0, bout4}, 32'd0);
        check("reset_ovf", {31'd0, ovf4}, 32'd0);
        rst4 = 1'b0; rst8 = 1'b0;
        @(negedge clk);

        $display("[TB] directed WIDTH=4 cases");
        apply_stimulus(4, 8'd9, 8'd3, 1'b0, 1'b1);  check_output(4, 0);
        apply_stimulus(4, 8'd3, 8'd9, 1'b0, 1'b1);  check_output(4, 0);
        apply_stimulus(4, 8'd0, 8'd0, 1'b1, 1'b1);  check_output(4, 0);
        apply_stimulus(4, 8'd8, 8'd1, 1'b0, 1'b1);  check_output(4, 0);
        apply_stimulus(4, 8'd7, 8'd15, 1'b0, 1'b1); check_output(4, 0);

        $display("[TB] start pulses during RUN are ignored");
        apply_stimulus(4, 8'd12, 8'd5, 1'b0, 1'b1);
        drive(4, 1'b1, 8'd15, 8'd0, 1'b1);
        @(negedge clk);
        drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        drive(4, 1'b1, 8'd1, 8'd14, 1'b1);
        @(negedge clk);
        drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
        check_output(4, 3);
        apply_stimulus(4, 8'd6, 8'd2, 1'b0, 1'b1);  check_output(4, 0);

        $display("[TB] reset aborts a run");
        apply_stimulus(4, 8'd9, 8'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_y", {28'd0, y4}, 32'd0);
        check("abort_borrowout", {31'd0, bout4}, 32'd0);
        check("abort_ovf", {31'd0, ovf4}, 32'd0);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done4) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        apply_stimulus(4, 8'd5, 8'd2, 1'b0, 1'b1);  check_output(4, 0);

        drive(4, 1'b1, 8'd9, 8'd3, 1'b0);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
        check("rst_beats_start", {31'd0, busy4}, 32'd0);

        $display("[TB] directed WIDTH=8 cases");
        apply_stimulus(8, 8'd200, 8'd55, 1'b0, 1'b1); check_output(8, 0);
        apply_stimulus(8, 8'd0, 8'd1, 1'b0, 1'b1);    check_output(8, 0);
        apply_stimulus(8, 8'd128, 8'd1, 1'b0, 1'b1);  check_output(8, 0);

        $display("[TB] random regression");
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            apply_stimulus(4, ra, rb, rbin, 1'b1); check_output(4, 0);
            apply_stimulus(8, ra, rb, rbin, 1'b1); check_output(8, 0);
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
